// File: rtl/avalon_onchip_ram_dual_slave.sv
// Dual Avalon-MM slave front end on one single-port RAM: round-robin arbitration,
// byte-enabled writes, and a 1- or 2-cycle registered read return per port.
module avalon_onchip_ram_dual_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 217088,
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic                    freeze,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  stall, req1, req2, grant1, grant2, accept;
    logic                  last_is_s1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_read, sel_write;
    logic [BE_W-1:0]       sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  in_range, do_write, do_read;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] cap_data;
    logic                  fin_valid, fin_port;
    logic [DATA_WIDTH-1:0] fin_data;

    assign stall = ~clken | reset_req;
    assign req1  = s1_chipselect & (s1_read | s1_write);
    assign req2  = s2_chipselect & (s2_read | s2_write);

    // On conflict the port that did not win last time goes first.
    assign grant1 = ~stall & req1 & (~req2 | ~last_is_s1);
    assign grant2 = ~stall & req2 & (~req1 |  last_is_s1);
    assign accept = grant1 | grant2;

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    assign sel_addr  = grant2 ? s2_address    : s1_address;
    assign sel_read  = grant2 ? s2_read       : s1_read;
    assign sel_write = grant2 ? s2_write      : s1_write;
    assign sel_be    = grant2 ? s2_byteenable : s1_byteenable;
    assign sel_wdata = grant2 ? s2_writedata  : s1_writedata;

    assign in_range = ({1'b0, sel_addr} < DEPTH_C);
    assign idx      = sel_addr[IDX_W-1:0];
    assign do_write = accept & sel_write & ~freeze & in_range;
    assign do_read  = accept & sel_read & ~sel_write;
    assign cap_data = in_range ? mem[idx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_is_s1 <= 1'b0;
        end else if (grant1) begin
            last_is_s1 <= 1'b1;
        end else if (grant2) begin
            last_is_s1 <= 1'b0;
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  mid_valid, mid_port;
            logic [DATA_WIDTH-1:0] mid_data;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mid_valid <= 1'b0;
                    mid_port  <= 1'b0;
                    mid_data  <= '0;
                end else if (!stall) begin
                    mid_valid <= do_read;
                    mid_port  <= grant2;
                    mid_data  <= cap_data;
                end
            end
            assign fin_valid = mid_valid;
            assign fin_port  = mid_port;
            assign fin_data  = mid_data;
        end else begin : g_lat1
            assign fin_valid = do_read;
            assign fin_port  = grant2;
            assign fin_data  = cap_data;
        end
    endgenerate

    // Valid drops during a stall so each read returns exactly one pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
            s1_readdata      <= '0;
            s2_readdata      <= '0;
        end else if (stall) begin
            s1_readdatavalid <= 1'b0;
            s2_readdatavalid <= 1'b0;
        end else begin
            s1_readdatavalid <= fin_valid & ~fin_port;
            s2_readdatavalid <= fin_valid &  fin_port;
            if (fin_valid & ~fin_port) s1_readdata <= fin_data;
            if (fin_valid &  fin_port) s2_readdata <= fin_data;
        end
    end
endmodule

// File: tb/tb_avalon_onchip_ram_dual_slave.sv
// Directed bench for the dual-slave RAM; one instance per legal read latency,
// both driven by the same stimulus.
module tb_avalon_onchip_ram_dual_slave;
    localparam int DW = 32;
    localparam int DP = 100;
    localparam int AW = 8;

    logic          clk = 0;
    logic          reset, clken, reset_req, freeze;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic [DW-1:0] a_s1_rd, a_s2_rd, b_s1_rd, b_s2_rd;
    logic          a_s1_v, a_s2_v, a_s1_w, a_s2_w, b_s1_v, b_s2_v, b_s1_w, b_s2_w;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    avalon_onchip_ram_dual_slave #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(a_s1_rd),
        .s1_readdatavalid(a_s1_v), .s1_waitrequest(a_s1_w),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(a_s2_rd),
        .s2_readdatavalid(a_s2_v), .s2_waitrequest(a_s2_w)
    );

    avalon_onchip_ram_dual_slave #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(b_s1_rd),
        .s1_readdatavalid(b_s1_v), .s1_waitrequest(b_s1_w),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(b_s2_rd),
        .s2_readdatavalid(b_s2_v), .s2_waitrequest(b_s2_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic s1_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        s1_chipselect = 1; s1_write = 1; s1_read = 0; s1_address = a; s1_writedata = d; s1_byteenable = be;
        #3;
        tests_run++;
        if (a_s1_w !== 1'b0) begin fails++; $display("FAIL wr_wait addr %0d: got %b expected 0", a, a_s1_w); end
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle();
        clken = 1; reset_req = 0; freeze = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({a_s1_v, a_s2_v, b_s1_v, b_s2_v} !== 4'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0000", {a_s1_v, a_s2_v, b_s1_v, b_s2_v}); end
        tests_run++;
        if ({a_s1_rd, a_s2_rd} !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", {a_s1_rd, a_s2_rd}); end
    endtask

    task automatic test_write_read();
        s1_wr(8'h10, 32'hDEADBEEF, 4'hF);
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        #3;
        tests_run++;
        if (a_s1_w !== 1'b0) begin fails++; $display("FAIL rd_wait: got %b expected 0", a_s1_w); end
        tick();
        idle();
        tests_run++;
        if (a_s1_v !== 1'b1 || a_s1_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got v=%b %h expected v=1 deadbeef", a_s1_v, a_s1_rd); end
        tests_run++;
        if (a_s2_v !== 1'b0 || a_s2_rd !== 32'h0) begin fails++; $display("FAIL s2_idle: got v=%b %h expected v=0 0", a_s2_v, a_s2_rd); end
        tick();
        tests_run++;
        if (a_s1_v !== 1'b0 || a_s1_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold: got v=%b %h expected v=0 deadbeef", a_s1_v, a_s1_rd); end
    endtask

    task automatic test_byteenable();
        s1_wr(8'd5, 32'hFFFFFFFF, 4'hF);
        s1_wr(8'd5, 32'h12345678, 4'h5);
        s1_chipselect = 1; s1_read = 1; s1_address = 8'd5;
        tick();
        idle();
        tests_run++;
        if (a_s1_v !== 1'b1 || a_s1_rd !== 32'hFF34FF78) begin fails++; $display("FAIL byteenable: got v=%b %h expected v=1 ff34ff78", a_s1_v, a_s1_rd); end
    endtask

    task automatic test_contention();
        do_reset();
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        s2_chipselect = 1; s2_read = 1; s2_address = 8'd5;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests_run++;
            if (a_s1_w !== (i % 2 == 1) || a_s2_w !== (i % 2 == 0)) begin
                fails++; $display("FAIL contention_wait %0d: got s1=%b s2=%b expected s1=%b s2=%b", i, a_s1_w, a_s2_w, i % 2 == 1, i % 2 == 0);
            end
            tick();
            tests_run++;
            if (a_s1_v !== (i % 2 == 0) || a_s2_v !== (i % 2 == 1)) begin
                fails++; $display("FAIL contention_valid %0d: got s1=%b s2=%b expected s1=%b s2=%b", i, a_s1_v, a_s2_v, i % 2 == 0, i % 2 == 1);
            end
            tests_run++;
            if ((i % 2 == 0 && a_s1_rd !== 32'hDEADBEEF) || (i % 2 == 1 && a_s2_rd !== 32'hFF34FF78)) begin
                fails++; $display("FAIL contention_data %0d: got s1=%h s2=%h expected deadbeef/ff34ff78", i, a_s1_rd, a_s2_rd);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_stall();
        int vcount = 0;
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        tick();
        idle();
        clken = 0;
        s2_chipselect = 1; s2_read = 1; s2_address = 8'd5;
        for (int i = 0; i < 3; i++) begin
            #3;
            tests_run++;
            if (b_s2_w !== 1'b1) begin fails++; $display("FAIL stall_wait %0d: got %b expected 1", i, b_s2_w); end
            tests_run++;
            if (b_s1_v !== 1'b0) begin fails++; $display("FAIL stall_early_valid %0d: got %b expected 0", i, b_s1_v); end
            tick();
        end
        clken = 1;
        idle();
        tests_run++;
        if (b_s1_v !== 1'b0) begin fails++; $display("FAIL stall_valid_c4: got %b expected 0", b_s1_v); end
        tick();
        tests_run++;
        if (b_s1_v !== 1'b1 || b_s1_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL stall_valid_c5: got v=%b %h expected v=1 deadbeef", b_s1_v, b_s1_rd); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b_s1_v === 1'b1) vcount++;
        end
        tests_run++;
        if (vcount !== 0) begin fails++; $display("FAIL stall_dup_valid: got %0d extra pulses expected 0", vcount); end
    endtask

    task automatic test_freeze_range();
        s1_wr(8'd7, 32'h01020304, 4'hF);
        freeze = 1;
        s1_wr(8'd7, 32'hAAAA5555, 4'hF);
        freeze = 0;
        s1_wr(8'h90, 32'h12121212, 4'hF);
        s1_chipselect = 1; s1_read = 1; s1_address = 8'd7;
        tick();
        tests_run++;
        if (a_s1_v !== 1'b1 || a_s1_rd !== 32'h01020304) begin fails++; $display("FAIL freeze: got v=%b %h expected v=1 01020304", a_s1_v, a_s1_rd); end
        s1_address = 8'd100;
        tick();
        tests_run++;
        if (a_s1_v !== 1'b1 || a_s1_rd !== 32'h0) begin fails++; $display("FAIL out_of_range: got v=%b %h expected v=1 0", a_s1_v, a_s1_rd); end
        s1_address = 8'h10;
        tick();
        idle();
        tests_run++;
        if (a_s1_v !== 1'b1 || a_s1_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL range_alias: got v=%b %h expected v=1 deadbeef", a_s1_v, a_s1_rd); end
    endtask

    task automatic test_reset_midflight();
        int vcount = 0;
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        tick();
        idle();
        reset = 1;
        #1;
        tests_run++;
        if ({a_s1_v, b_s1_v} !== 2'b00) begin fails++; $display("FAIL midflight_async: got %b expected 00", {a_s1_v, b_s1_v}); end
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({a_s1_v, a_s2_v, b_s1_v, b_s2_v} !== 4'b0) vcount++;
        end
        tests_run++;
        if (vcount !== 0) begin fails++; $display("FAIL midflight_valid: got %0d pulses expected 0", vcount); end
        s1_chipselect = 1; s1_read = 1; s1_address = 8'h10;
        s2_chipselect = 1; s2_read = 1; s2_address = 8'd5;
        #3;
        tests_run++;
        if ({a_s1_w, a_s2_w, b_s1_w, b_s2_w} !== 4'b0101) begin
            fails++; $display("FAIL post_reset_grant: got %b expected 0101", {a_s1_w, a_s2_w, b_s1_w, b_s2_w});
        end
        tick();
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_contention();
        test_stall();
        test_freeze_range();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/avalon_onchip_ram_dual_slave.md
Name: avalon_onchip_ram_dual_slave

Overview:
- Parametrised on-chip RAM that generalises the single-port Avalon RAM.
- Configurable width, depth and read latency.
- Two Avalon-MM slave ports (s1, s2) share one single-port storage array through a round-robin arbiter, with waitrequest/readdatavalid handshakes.
- Sits in the Qsys system as the shared scratch/descriptor memory between the NIOS data master and a DMA master.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 217088, number of words.
- ADDR_WIDTH, 18, word-address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clken  in  1  global clock enable; 0 stalls the block
- reset_req  in  1  reset-pending request; 1 stalls the block exactly like clken=0
- freeze  in  1  write-protect; 1 discards writes
- s1_address  in  ADDR_WIDTH  port 1 word address
- s1_chipselect  in  1  port 1 select
- s1_read  in  1  port 1 read request
- s1_write  in  1  port 1 write request
- s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
- s1_writedata  in  DATA_WIDTH  port 1 write data
- s1_readdata  out  DATA_WIDTH  port 1 read data
- s1_readdatavalid  out  1  port 1 read data valid
- s1_waitrequest  out  1  port 1 stall
- s2_*  identical set for port 2

Behaviour:
- Request definitions:
  - reqN = sN_chipselect & (sN_read | sN_write).
  - read and write both high on one port: treated as a write; the read is ignored.
- Stall: stall = ~clken | reset_req.
  - While stalled: no grant, waitrequest = reqN for both ports.
  - Read pipeline and registers hold.
- Arbitration (combinational, same cycle):
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port not granted most recently.
  - last_grant is updated on every grant.
  - sN_waitrequest = reqN & ~grantN. It is 0 when not requesting.
  - A request is accepted in the cycle where it is granted.
- Write, on the accepting clock edge:
  - Each byte lane with byteenable=1 is updated; other lanes are untouched.
  - The write is discarded (but still accepted, waitrequest low) if freeze=1 or address >= DEPTH.
- Read:
  - The array is sampled at the accepting edge.
  - sN_readdatavalid pulses for exactly 1 cycle, READ_LATENCY cycles after acceptance, only on the requesting port.
  - readdata is the word at that address, or 0 when address >= DEPTH.
  - readdata holds its last value when readdatavalid=0.
  - Back-to-back accepted reads give back-to-back valids, in order. Throughput is one access per cycle in total.
- Stall during latency: the pipeline freezes and valid is delayed by the number of stalled cycles. No data is lost or duplicated.
- Read-after-write:
  - Only one access occurs per cycle, so no same-cycle conflict exists.
  - A read accepted the cycle after a write to the same address returns the new data.
- Reset, asynchronous:
  - Both readdatavalid = 0, both readdata = 0.
  - Pipeline cleared; reads in flight are dropped with no valid pulse.
  - last_grant = s2, so s1 wins the first conflict.
  - Array contents are not reset; contents after power-up are undefined.
- waitrequest is combinational from inputs and state. readdata and readdatavalid are registered.

Test Plan:
1. Single-port write then read: s1 writes 0xDEADBEEF to addr 0x10 with be=0xF, then reads addr 0x10 -> s1_readdatavalid one cycle later (LAT=1) with 0xDEADBEEF; s2 outputs idle.
2. Byte enables: fill addr 5 with 0xFFFFFFFF, write 0x12345678 with be=0x5, read -> 0xFF34FF78.
3. Contention: s1 and s2 both request reads continuously from reset.
   - Required grants: s1, s2, s1, s2.
   - waitrequest alternates per port; each port gets one valid every 2 cycles with the correct data.
4. Stall: clken=0 for 3 cycles right after a read is accepted with LAT=2 -> valid arrives at 2+3=5 cycles, exactly once; requests issued during the stall see waitrequest=1.
5. Freeze and range: freeze=1 write 0xAAAA5555 to addr 7 -> read returns the prior value; read addr DEPTH -> 0 with valid.
6. Reset mid-flight: assert reset the cycle after a read is accepted -> no readdatavalid; after release the s1/s2 conflict is granted to s1 first.
